mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/pipeline_pkg.sv | 44 ++++
 rtl/mem_load_align.sv | 41 ++++
 rtl/mem_stage.sv | 209 ++++++++++++++++++++
 tb/tb_mem_stage.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipeline_pkg : shared encodings and types for the MEM pipeline stage  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package pipeline_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_LOAD = 2'b01;
  localparam logic [1:0] RES_PC4  = 2'b10;
  localparam logic [1:0] RES_ALU2 = 2'b11;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } acc_size_t;

  // Unsigned encodings only exist for loads; stores fall back to word size.
  function automatic acc_size_t access_size(input logic [2:0] f3, input logic is_load);
    acc_size_t sz;
    case (f3)
      F3_B:    sz = SZ_B;
      F3_H:    sz = SZ_H;
      F3_BU:   sz = is_load ? SZ_B : SZ_W;
      F3_HU:   sz = is_load ? SZ_H : SZ_W;
      default: sz = SZ_W;
    endcase
    return sz;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_load_align.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_load_align : extracts and extends a load value from a bus word    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
import pipeline_pkg::*;

module mem_load_align (
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    case (addr_lo_i)
      2'd0:    w_byte = rdata_i[7:0];
      2'd1:    w_byte = rdata_i[15:8];
      2'd2:    w_byte = rdata_i[23:16];
      default: w_byte = rdata_i[31:24];
    endcase
    w_half = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    data_o = rdata_i;
    case (funct3_i)
      F3_B:    data_o = {{24{w_byte[7]}}, w_byte};
      F3_BU:   data_o = {24'h000000, w_byte};
      F3_H:    data_o = {{16{w_half[15]}}, w_half};
      F3_HU:   data_o = {16'h0000, w_half};
      default: data_o = rdata_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_stage : data-bus access, stall generation and MEM/WB register     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
import pipeline_pkg::*;

module mem_stage #(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] alu_result_in,
  input  logic [XLEN-1:0] write_data_in,
  input  logic [XLEN-1:0] pc_plus4_in,
  input  logic [4:0]      rd_in,
  input  logic [2:0]      funct3_in,
  input  logic            reg_write_in,
  input  logic            mem_read_in,
  input  logic            mem_write_in,
  input  logic [1:0]      result_src_in,
  output logic            dbus_req,
  output logic            dbus_we,
  output logic [XLEN-1:0] dbus_addr,
  output logic [XLEN-1:0] dbus_wdata,
  output logic [3:0]      dbus_be,
  input  logic            dbus_ready,
  input  logic [XLEN-1:0] dbus_rdata,
  output logic            stall_out,
  output logic            misalign_out,
  output logic [XLEN-1:0] wb_data_out,
  output logic [4:0]      wb_rd_out,
  output logic            wb_reg_write_out
);

  mem_state_t state_q, state_d;

  logic [XLEN-1:0] req_addr_q;
  logic [XLEN-1:0] req_wdata_q;
  logic [3:0]      req_be_q;
  logic            req_we_q;
  logic [2:0]      req_f3_q;
  logic [4:0]      req_rd_q;
  logic            req_rw_q;
  logic [1:0]      req_rsrc_q;
  logic            misalign_q;

  logic            w_mem_op;
  logic            w_is_load;
  acc_size_t       w_size;
  logic            w_misalign;
  logic            w_issue;
  logic            w_misalign_now;
  logic            w_req;
  logic            w_new_we;
  logic [3:0]      w_new_be;
  logic [XLEN-1:0] w_new_wdata;
  logic            w_in_wait;
  logic [XLEN-1:0] w_cur_addr;
  logic [2:0]      w_cur_f3;
  logic [4:0]      w_cur_rd;
  logic            w_cur_rw;
  logic [1:0]      w_cur_rsrc;
  logic [XLEN-1:0] w_load_data;
  logic [XLEN-1:0] w_wb_sel;

  // Read wins when both control bits are set.
  assign w_mem_op   = mem_read_in | mem_write_in;
  assign w_is_load  = mem_read_in;
  assign w_size     = access_size(funct3_in, w_is_load);
  assign w_misalign = ((w_size == SZ_H) && alu_result_in[0]) ||
                      ((w_size == SZ_W) && (alu_result_in[1:0] != 2'b00));
  assign w_issue        = (state_q == IDLE) && w_mem_op && !w_misalign;
  assign w_misalign_now = (state_q == IDLE) && w_mem_op && w_misalign;
  assign w_new_we       = mem_write_in & ~mem_read_in;

  always_comb begin
    w_new_be    = 4'b1111;
    w_new_wdata = '0;
    if (!w_is_load) begin
      case (w_size)
        SZ_B: begin
          w_new_be    = 4'b0001 << alu_result_in[1:0];
          w_new_wdata = {4{write_data_in[7:0]}};
        end
        SZ_H: begin
          w_new_be    = 4'b0011 << alu_result_in[1:0];
          w_new_wdata = {2{write_data_in[15:0]}};
        end
        default: begin
          w_new_be    = 4'b1111;
          w_new_wdata = write_data_in;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Once parked in WAIT the bus sees only the captured request.
  always_comb begin
    state_d    = state_q;
    w_req      = 1'b0;
    dbus_we    = w_new_we;
    dbus_addr  = {alu_result_in[XLEN-1:2], 2'b00};
    dbus_wdata = w_new_wdata;
    dbus_be    = w_new_be;
    case (state_q)
      IDLE: begin
        if (w_issue) begin
          w_req = 1'b1;
          if (!dbus_ready) begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        w_req      = 1'b1;
        dbus_we    = req_we_q;
        dbus_addr  = {req_addr_q[XLEN-1:2], 2'b00};
        dbus_wdata = req_wdata_q;
        dbus_be    = req_be_q;
        if (dbus_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Held inputs could still look like a request while reset is high.
  assign dbus_req  = w_req & ~reset;
  assign stall_out = dbus_req & ~dbus_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_be_q    <= 4'b0000;
      req_we_q    <= 1'b0;
      req_f3_q    <= 3'b000;
      req_rd_q    <= 5'd0;
      req_rw_q    <= 1'b0;
      req_rsrc_q  <= 2'b00;
    end else if (w_issue && !dbus_ready) begin
      req_addr_q  <= alu_result_in;
      req_wdata_q <= w_new_wdata;
      req_be_q    <= w_new_be;
      req_we_q    <= w_new_we;
      req_f3_q    <= funct3_in;
      req_rd_q    <= rd_in;
      req_rw_q    <= reg_write_in;
      req_rsrc_q  <= result_src_in;
    end
  end

  assign w_in_wait  = (state_q == WAIT);
  assign w_cur_addr = w_in_wait ? req_addr_q : alu_result_in;
  assign w_cur_f3   = w_in_wait ? req_f3_q   : funct3_in;
  assign w_cur_rd   = w_in_wait ? req_rd_q   : rd_in;
  assign w_cur_rw   = w_in_wait ? req_rw_q   : reg_write_in;
  assign w_cur_rsrc = w_in_wait ? req_rsrc_q : result_src_in;

  mem_load_align u_load_align (
    .rdata_i   (dbus_rdata),
    .addr_lo_i (w_cur_addr[1:0]),
    .funct3_i  (w_cur_f3),
    .data_o    (w_load_data)
  );

  always_comb begin
    w_wb_sel = w_cur_addr;
    case (w_cur_rsrc)
      RES_LOAD: w_wb_sel = w_load_data;
      RES_PC4:  w_wb_sel = pc_plus4_in;
      default:  w_wb_sel = w_cur_addr;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wb_data_out      <= '0;
      wb_rd_out        <= 5'd0;
      wb_reg_write_out <= 1'b0;
      misalign_q       <= 1'b0;
    end else begin
      misalign_q <= w_misalign_now;
      if (stall_out) begin
        wb_data_out      <= '0;
        wb_rd_out        <= 5'd0;
        wb_reg_write_out <= 1'b0;
      end else begin
        wb_data_out      <= w_wb_sel;
        wb_rd_out        <= w_cur_rd;
        wb_reg_write_out <= w_cur_rw & (w_cur_rd != 5'd0) & ~w_misalign_now;
      end
    end
  end

  assign misalign_out = misalign_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_stage : directed self-checking bench for mem_stage             |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_mem_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] alu_result_in = '0;
  logic [31:0] write_data_in = '0;
  logic [31:0] pc_plus4_in = '0;
  logic [4:0]  rd_in = '0;
  logic [2:0]  funct3_in = '0;
  logic        reg_write_in = 1'b0;
  logic        mem_read_in = 1'b0;
  logic        mem_write_in = 1'b0;
  logic [1:0]  result_src_in = '0;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [31:0] dbus_wdata;
  logic [3:0]  dbus_be;
  logic        dbus_ready = 1'b1;
  logic [31:0] dbus_rdata = '0;
  logic        stall_out;
  logic        misalign_out;
  logic [31:0] wb_data_out;
  logic [4:0]  wb_rd_out;
  logic        wb_reg_write_out;

  int n_cmp = 0;
  int n_err = 0;

  mem_stage #(.XLEN(32)) dut (
    .clock            (clock),
    .reset            (reset),
    .alu_result_in    (alu_result_in),
    .write_data_in    (write_data_in),
    .pc_plus4_in      (pc_plus4_in),
    .rd_in            (rd_in),
    .funct3_in        (funct3_in),
    .reg_write_in     (reg_write_in),
    .mem_read_in      (mem_read_in),
    .mem_write_in     (mem_write_in),
    .result_src_in    (result_src_in),
    .dbus_req         (dbus_req),
    .dbus_we          (dbus_we),
    .dbus_addr        (dbus_addr),
    .dbus_wdata       (dbus_wdata),
    .dbus_be          (dbus_be),
    .dbus_ready       (dbus_ready),
    .dbus_rdata       (dbus_rdata),
    .stall_out        (stall_out),
    .misalign_out     (misalign_out),
    .wb_data_out      (wb_data_out),
    .wb_rd_out        (wb_rd_out),
    .wb_reg_write_out (wb_reg_write_out)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [31:0] alu, input logic [31:0] wd, input logic [2:0] f3,
                       input logic [4:0] rd, input logic rw, input logic mr, input logic mw,
                       input logic [1:0] rs);
    alu_result_in = alu;
    write_data_in = wd;
    funct3_in     = f3;
    rd_in         = rd;
    reg_write_in  = rw;
    mem_read_in   = mr;
    mem_write_in  = mw;
    result_src_in = rs;
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Reset state
    repeat (3) tick;
    chk("rst_wb_data", wb_data_out, 32'h0);
    chk("rst_wb_rd", {27'd0, wb_rd_out}, 32'd0);
    chk("rst_wb_rw", {31'd0, wb_reg_write_out}, 32'd0);
    chk("rst_misalign", {31'd0, misalign_out}, 32'd0);
    chk("rst_req", {31'd0, dbus_req}, 32'd0);

    // Zero-wait LW
    @(negedge clock);
    reset = 1'b0;
    drive(32'h100, 32'h0, 3'b010, 5'd5, 1'b1, 1'b1, 1'b0, 2'b01);
    dbus_ready = 1'b1;
    dbus_rdata = 32'hDEADBEEF;
    #1;
    chk("lw_req", {31'd0, dbus_req}, 32'd1);
    chk("lw_stall", {31'd0, stall_out}, 32'd0);
    chk("lw_addr", dbus_addr, 32'h100);
    chk("lw_be", {28'd0, dbus_be}, 32'hF);
    chk("lw_we", {31'd0, dbus_we}, 32'd0);
    tick;
    chk("lw_wb_data", wb_data_out, 32'hDEADBEEF);
    chk("lw_wb_rd", {27'd0, wb_rd_out}, 32'd5);
    chk("lw_wb_rw", {31'd0, wb_reg_write_out}, 32'd1);

    // Sub-word loads from rdata 0x80FF0000
    @(negedge clock);
    drive(32'h103, 32'h0, 3'b000, 5'd6, 1'b1, 1'b1, 1'b0, 2'b01);
    dbus_rdata = 32'h80FF0000;
    tick;
    chk("lb_wb_data", wb_data_out, 32'hFFFFFF80);
    @(negedge clock);
    funct3_in = 3'b100;
    tick;
    chk("lbu_wb_data", wb_data_out, 32'h00000080);
    @(negedge clock);
    drive(32'h102, 32'h0, 3'b001, 5'd6, 1'b1, 1'b1, 1'b0, 2'b01);
    tick;
    chk("lh_wb_data", wb_data_out, 32'hFFFF80FF);
    @(negedge clock);
    funct3_in = 3'b101;
    tick;
    chk("lhu_wb_data", wb_data_out, 32'h000080FF);

    // SB lane replication
    @(negedge clock);
    drive(32'h301, 32'h000000AB, 3'b000, 5'd0, 1'b0, 1'b0, 1'b1, 2'b00);
    #1;
    chk("sb_be", {28'd0, dbus_be}, 32'h2);
    chk("sb_wdata", dbus_wdata, 32'hABABABAB);
    chk("sb_we", {31'd0, dbus_we}, 32'd1);
    tick;

    // SH with three wait cycles; inputs disturbed while waiting
    @(negedge clock);
    drive(32'h206, 32'h00001234, 3'b001, 5'd0, 1'b0, 1'b0, 1'b1, 2'b00);
    dbus_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        @(negedge clock);
        alu_result_in = 32'hFFF0;
        write_data_in = 32'h0000BEEF;
      end
      #1;
      chk($sformatf("sh_be_%0d", i), {28'd0, dbus_be}, 32'hC);
      chk($sformatf("sh_wdata_%0d", i), dbus_wdata, 32'h12341234);
      chk($sformatf("sh_addr_%0d", i), dbus_addr, 32'h204);
      chk($sformatf("sh_stall_%0d", i), {31'd0, stall_out}, 32'd1);
      tick;
      chk($sformatf("sh_bubble_rw_%0d", i), {31'd0, wb_reg_write_out}, 32'd0);
      chk($sformatf("sh_bubble_data_%0d", i), wb_data_out, 32'h0);
    end
    @(negedge clock);
    dbus_ready = 1'b1;
    #1;
    chk("sh_done_req", {31'd0, dbus_req}, 32'd1);
    chk("sh_done_stall", {31'd0, stall_out}, 32'd0);
    chk("sh_done_addr", dbus_addr, 32'h204);
    tick;

    // LW with one wait cycle; writeback uses the captured rd
    @(negedge clock);
    drive(32'h600, 32'h0, 3'b010, 5'd12, 1'b1, 1'b1, 1'b0, 2'b01);
    dbus_ready = 1'b0;
    #1;
    chk("lww_stall", {31'd0, stall_out}, 32'd1);
    tick;
    chk("lww_bubble_rw", {31'd0, wb_reg_write_out}, 32'd0);
    @(negedge clock);
    rd_in      = 5'd13;
    dbus_ready = 1'b1;
    dbus_rdata = 32'hCAFEF00D;
    tick;
    chk("lww_wb_data", wb_data_out, 32'hCAFEF00D);
    chk("lww_wb_rd", {27'd0, wb_rd_out}, 32'd12);
    chk("lww_wb_rw", {31'd0, wb_reg_write_out}, 32'd1);

    // Misaligned SW
    @(negedge clock);
    drive(32'h101, 32'h55667788, 3'b010, 5'd7, 1'b1, 1'b0, 1'b1, 2'b00);
    #1;
    chk("mis_req", {31'd0, dbus_req}, 32'd0);
    chk("mis_stall", {31'd0, stall_out}, 32'd0);
    tick;
    chk("mis_pulse", {31'd0, misalign_out}, 32'd1);
    chk("mis_wb_rw", {31'd0, wb_reg_write_out}, 32'd0);
    @(negedge clock);
    drive(32'h10, 32'h0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00);
    tick;
    chk("mis_pulse_end", {31'd0, misalign_out}, 32'd0);

    // Reset in the second WAIT cycle
    @(negedge clock);
    drive(32'h400, 32'h0, 3'b010, 5'd9, 1'b1, 1'b1, 1'b0, 2'b01);
    dbus_ready = 1'b0;
    tick;
    @(negedge clock);
    tick;
    #2;
    reset = 1'b1;
    #1;
    chk("rstw_req", {31'd0, dbus_req}, 32'd0);
    chk("rstw_stall", {31'd0, stall_out}, 32'd0);
    chk("rstw_wb_data", wb_data_out, 32'h0);
    chk("rstw_wb_rd", {27'd0, wb_rd_out}, 32'd0);
    chk("rstw_wb_rw", {31'd0, wb_reg_write_out}, 32'd0);
    tick;
    @(negedge clock);
    reset = 1'b0;
    drive(32'h500, 32'h0, 3'b010, 5'd10, 1'b1, 1'b1, 1'b0, 2'b01);
    dbus_ready = 1'b1;
    dbus_rdata = 32'h11223344;
    #1;
    chk("rel_addr", dbus_addr, 32'h500);
    chk("rel_stall", {31'd0, stall_out}, 32'd0);
    tick;
    chk("rel_wb_data", wb_data_out, 32'h11223344);
    chk("rel_wb_rd", {27'd0, wb_rd_out}, 32'd10);
    chk("rel_wb_rw", {31'd0, wb_reg_write_out}, 32'd1);
    chk("rel_misalign", {31'd0, misalign_out}, 32'd0);

    // Non-memory writeback selections
    @(negedge clock);
    drive(32'h55, 32'h0, 3'b000, 5'd0, 1'b1, 1'b0, 1'b0, 2'b00);
    #1;
    chk("alu_req", {31'd0, dbus_req}, 32'd0);
    tick;
    chk("alu_rd0_rw", {31'd0, wb_reg_write_out}, 32'd0);
    chk("alu_rd0_data", wb_data_out, 32'h55);
    @(negedge clock);
    drive(32'h99, 32'h0, 3'b000, 5'd3, 1'b1, 1'b0, 1'b0, 2'b10);
    pc_plus4_in = 32'h44;
    tick;
    chk("pc4_data", wb_data_out, 32'h44);
    chk("pc4_rw", {31'd0, wb_reg_write_out}, 32'd1);
    @(negedge clock);
    drive(32'h77, 32'h0, 3'b000, 5'd4, 1'b1, 1'b0, 1'b0, 2'b11);
    tick;
    chk("alu11_data", wb_data_out, 32'h77);
    chk("alu11_rd", {27'd0, wb_rd_out}, 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
